// File: rtl/bg_pkg.sv
// Shared definitions for the background-removal controller: one-hot state
// encoding, pixel channel width and a constant log2 helper.
package bg_pkg;

    localparam int PIX_W   = 9;
    localparam int MEAN_MAX = 255;

    typedef enum logic [7:0] {
        S_IDLE      = 8'b0000_0001,
        S_SUM_START = 8'b0000_0010,
        S_SUM_WAIT  = 8'b0000_0100,
        S_SUM_ACC   = 8'b0000_1000,
        S_MEAN      = 8'b0001_0000,
        S_BG_START  = 8'b0010_0000,
        S_BG_WAIT   = 8'b0100_0000,
        S_DONE      = 8'b1000_0000
    } state_e;

    // Ceiling log2; callers pass powers of two so this is exact.
    function automatic int log2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_mean_acc.sv
// Three-channel (R/G/B) sum accumulator with shift-to-mean and saturation
// to an 8-bit range; the mean is held in registers between loads.
module bg_mean_acc
    import bg_pkg::*;
#(
    parameter int SUM_W = 9,
    parameter int ACC_W = 11,
    parameter int SHIFT = 2
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        clr_i,
    input  logic                        add_i,
    input  logic                        load_i,
    input  logic [2:0][SUM_W-1:0]       sum_i,
    output logic [2:0][PIX_W-1:0]       exp_o
);

    logic [2:0][ACC_W-1:0] acc_q;
    logic [2:0][ACC_W-1:0] shifted;
    logic [2:0][PIX_W-1:0] mean_d;
    logic [2:0][PIX_W-1:0] exp_q;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            shifted[c] = acc_q[c] >> SHIFT;
            mean_d[c]  = (shifted[c] > ACC_W'(MEAN_MAX)) ? PIX_W'(MEAN_MAX)
                                                          : shifted[c][PIX_W-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
            exp_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (clr_i)      acc_q[c] <= '0;
                else if (add_i) acc_q[c] <= acc_q[c] + ACC_W'(sum_i[c]);
                if (load_i)     exp_q[c] <= mean_d[c];
            end
        end
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/bg_removal_ctrl.sv
// Sequencer for NUM_PE background-removal elements: sum, mean, bg pass, done.
// Optional wait watchdog enabled by defining BG_REMOVAL_CTRL_TIMEOUT_EN.
module bg_removal_ctrl
    import bg_pkg::*;
#(
    parameter int NUM_PE     = 4,
    parameter int PIX_PER_PE = 1,
    parameter int SUM_W      = 9 * PIX_PER_PE,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    HostAck,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err,
    output logic [NUM_PE-1:0]       pe_start_sum,
    output logic [NUM_PE-1:0]       pe_start_bg,
    output logic                    pe_ack,
    input  logic [NUM_PE-1:0]       pe_sum_done,
    input  logic [NUM_PE-1:0]       pe_bg_done,
    input  logic [NUM_PE*SUM_W-1:0] pe_red_sum,
    input  logic [NUM_PE*SUM_W-1:0] pe_green_sum,
    input  logic [NUM_PE*SUM_W-1:0] pe_blue_sum,
    output logic [PIX_W-1:0]        red_exp,
    output logic [PIX_W-1:0]        green_exp,
    output logic [PIX_W-1:0]        blue_exp
);

    localparam int KW    = log2i(NUM_PE);
    localparam int ACC_W = SUM_W + KW;
    localparam int SHIFT = log2i(NUM_PE * PIX_PER_PE);

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic            ack_q;
    logic            sum_all_q;
    logic            bg_all_q;
    logic            in_wait;
    logic            wait_ok;
    logic            wd_hit;
    logic            timeout;

    // Done vectors are registered before the FSM sees them to keep the
    // element-to-controller path off the state logic.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_all_q <= 1'b0;
            bg_all_q  <= 1'b0;
        end else begin
            sum_all_q <= &pe_sum_done;
            bg_all_q  <= &pe_bg_done;
        end
    end

    assign in_wait = (state_q == S_SUM_WAIT) || (state_q == S_BG_WAIT);
    assign wait_ok = ((state_q == S_SUM_WAIT) && sum_all_q) ||
                     ((state_q == S_BG_WAIT)  && bg_all_q);
    assign timeout = in_wait && !wait_ok && wd_hit;

`ifdef BG_REMOVAL_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt_q;
    logic          err_q;

    // Counter idles at zero outside the wait states, so each wait starts fresh.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)         wcnt_q <= '0;
        else if (!in_wait) wcnt_q <= '0;
        else               wcnt_q <= wcnt_q + 1'b1;
    end
    assign wd_hit = (wcnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                              err_q <= 1'b0;
        else if (timeout)                       err_q <= 1'b1;
        else if (state_q == S_DONE && HostAck)  err_q <= 1'b0;
    end
    assign Err = err_q;
`else
    assign wd_hit = 1'b0;
    assign Err    = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE:      if (Start) state_q <= S_SUM_START;
                S_SUM_START: begin
                    state_q <= S_SUM_WAIT;
                    k_q     <= '0;
                end
                S_SUM_WAIT: begin
                    if (wait_ok) begin
                        state_q <= S_SUM_ACC;
                        ack_q   <= 1'b1;
                    end else if (timeout) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                    end
                end
                S_SUM_ACC: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == KW'(NUM_PE - 1)) state_q <= S_MEAN;
                end
                S_MEAN:      state_q <= S_BG_START;
                S_BG_START:  state_q <= S_BG_WAIT;
                S_BG_WAIT: begin
                    if (wait_ok || timeout) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                    end
                end
                S_DONE:      if (HostAck) state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign pe_start_sum = {NUM_PE{state_q == S_SUM_START}};
    assign pe_start_bg  = {NUM_PE{state_q == S_BG_START}};
    assign pe_ack       = ack_q;

    logic [2:0][SUM_W-1:0] sum_sel;
    logic [2:0][PIX_W-1:0] exp_w;

    assign sum_sel[0] = pe_red_sum  [k_q*SUM_W +: SUM_W];
    assign sum_sel[1] = pe_green_sum[k_q*SUM_W +: SUM_W];
    assign sum_sel[2] = pe_blue_sum [k_q*SUM_W +: SUM_W];

    bg_mean_acc #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_mean (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr_i  (state_q == S_SUM_START),
        .add_i  (state_q == S_SUM_ACC),
        .load_i (state_q == S_MEAN),
        .sum_i  (sum_sel),
        .exp_o  (exp_w)
    );

    assign red_exp   = exp_w[0];
    assign green_exp = exp_w[1];
    assign blue_exp  = exp_w[2];

endmodule

// File: tb/tb_bg_removal_ctrl.sv
// Self-checking bench for bg_removal_ctrl: table of sum vectors with a mean
// scoreboard, plus sequences for staggered done, mid-run reset, watchdog.
module tb_bg_removal_ctrl;

    localparam int NPE = 4;
    localparam int SW  = 9;

    logic                Clk = 1'b0;
    logic                Reset = 1'b1;
    logic                Start = 1'b0;
    logic                HostAck = 1'b0;
    logic                Busy, Done, Err, pe_ack;
    logic [NPE-1:0]      pe_start_sum, pe_start_bg;
    logic [NPE-1:0]      pe_sum_done = '0;
    logic [NPE-1:0]      pe_bg_done  = '0;
    logic [NPE*SW-1:0]   pe_red_sum = '0, pe_green_sum = '0, pe_blue_sum = '0;
    logic [8:0]          red_exp, green_exp, blue_exp;

    bg_removal_ctrl #(.NUM_PE(NPE), .PIX_PER_PE(1), .SUM_W(SW), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .HostAck(HostAck),
        .Busy(Busy), .Done(Done), .Err(Err),
        .pe_start_sum(pe_start_sum), .pe_start_bg(pe_start_bg), .pe_ack(pe_ack),
        .pe_sum_done(pe_sum_done), .pe_bg_done(pe_bg_done),
        .pe_red_sum(pe_red_sum), .pe_green_sum(pe_green_sum), .pe_blue_sum(pe_blue_sum),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0][8:0] r, g, b;
        logic [8:0]      er, eg, eb;
    } vec_t;

    typedef struct packed { logic [8:0] r, g, b; } rgb_t;

    vec_t vecs[4];
    rgb_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_err"}, Err, 0);
        chk({tag, "_ack"}, pe_ack, 0);
        chk({tag, "_pulses"}, {pe_start_sum, pe_start_bg}, 0);
        chk({tag, "_exp"}, {red_exp, green_exp, blue_exp}, 0);
    endtask

    // Drive sums, pulse Start, and leave the DUT in SUM_WAIT.
    task automatic start_run(input vec_t v, input bit push);
        rgb_t e;
        pe_red_sum = v.r; pe_green_sum = v.g; pe_blue_sum = v.b;
        if (push) begin
            e.r = v.er; e.g = v.eg; e.b = v.eb;
            sb.push_back(e);
        end
        Start = 1'b1;
        tick;
        Start = 1'b0;
        chk("start_sum_on", pe_start_sum, 4'hF);
        chk("busy_sum_start", Busy, 1);
        tick;
        chk("start_sum_off", pe_start_sum, 0);
    endtask

    task automatic sum_phase(input bit stagger);
        if (stagger) begin
            pe_sum_done = 4'b0001; tick; chk("ack_0001", pe_ack, 0);
            pe_sum_done = 4'b0011; tick; chk("ack_0011", pe_ack, 0);
        end
        pe_sum_done = 4'hF;
        tick;
        chk("ack_early", pe_ack, 0);
        tick;
        chk("ack_sum", pe_ack, 1);
        pe_sum_done = '0;
    endtask

    task automatic acc_to_bg;
        int n, acks;
        acks = 1;
        for (n = 1; n <= 10; n++) begin
            tick;
            if (pe_ack) acks++;
            chk("busy_acc", Busy, 1);
            if (pe_start_bg != 0) break;
        end
        chk("acc_cycles", n, 5);
        chk("ack_count", acks, 1);
        chk("start_bg_on", pe_start_bg, 4'hF);
        tick;
        chk("start_bg_off", pe_start_bg, 0);
    endtask

    task automatic sb_compare(input string tag);
        rgb_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_red"}, red_exp, e.r);
            chk({tag, "_green"}, green_exp, e.g);
            chk({tag, "_blue"}, blue_exp, e.b);
        end
    endtask

    task automatic bg_phase;
        pe_bg_done = 4'hF;
        tick;
        chk("done_early", Done, 0);
        chk("busy_bg_wait", Busy, 1);
        tick;
        chk("done_2cyc", Done, 1);
        chk("ack_bg", pe_ack, 1);
        chk("err_normal", Err, 0);
        pe_bg_done = '0;
        sb_compare("mean");
    endtask

    task automatic host_ack;
        HostAck = 1'b1;
        tick;
        HostAck = 1'b0;
        chk("done_cleared", Done, 0);
        chk("busy_idle", Busy, 0);
    endtask

    task automatic full_run(input vec_t v, input bit stagger);
        start_run(v, 1'b1);
        sum_phase(stagger);
        acc_to_bg;
        bg_phase;
        host_ack;
    endtask

    initial begin
        vecs[0] = '{r: {9'd40, 9'd30, 9'd20, 9'd10}, g: {4{9'd400}}, b: '0,
                    er: 9'd25, eg: 9'd255, eb: 9'd0};
        vecs[1] = '{r: {4{9'd511}}, g: {9'd4, 9'd3, 9'd2, 9'd1}, b: {4{9'd255}},
                    er: 9'd255, eg: 9'd2, eb: 9'd255};
        vecs[2] = '{r: {9'd0, 9'd0, 9'd0, 9'd3}, g: {9'd103, 9'd102, 9'd101, 9'd100},
                    b: {9'd13, 9'd11, 9'd9, 9'd7}, er: 9'd0, eg: 9'd101, eb: 9'd10};
        vecs[3] = '{r: {9'd255, 9'd256, 9'd256, 9'd256}, g: {4{9'd256}},
                    b: {9'd0, 9'd0, 9'd0, 9'd200}, er: 9'd255, eg: 9'd255, eb: 9'd50};

        tick; tick;
        chk_reset_state("reset");
        Reset = 1'b0;
        tick;
        chk("idle_busy", Busy, 0);

        for (int i = 0; i < 4; i++) full_run(vecs[i], 1'b0);

        // Staggered element completion.
        full_run(vecs[1], 1'b1);

        // Reset while accumulating at k=2, then a clean rerun.
        full_run(vecs[0], 1'b0);
        start_run(vecs[2], 1'b0);
        sum_phase(1'b0);
        tick; tick;
        Reset = 1'b1;
        #1;
        chk_reset_state("midreset");
        tick;
        Reset = 1'b0;
        tick;
        full_run(vecs[2], 1'b0);

        // Watchdog on a stuck bg_done.
        start_run(vecs[3], 1'b1);
        sum_phase(1'b0);
        acc_to_bg;
`ifdef BG_REMOVAL_CTRL_TIMEOUT_EN
        begin
            int n;
            for (n = 1; n <= 40; n++) begin
                tick;
                if (Done) break;
            end
            chk("wd_cycles", n, 15);
            chk("wd_err", Err, 1);
            chk("wd_ack", pe_ack, 1);
            sb_compare("wd_mean");
            HostAck = 1'b1;
            tick;
            HostAck = 1'b0;
            chk("wd_err_clear", Err, 0);
            chk("wd_idle", Busy, 0);
        end
`else
        repeat (30) tick;
        chk("nowd_done", Done, 0);
        chk("nowd_err", Err, 0);
        chk("nowd_busy", Busy, 1);
        sb_compare("nowd_mean");
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        tick;
`endif

        // Start and HostAck together in DONE: back to IDLE, restart next cycle.
        start_run(vecs[0], 1'b1);
        sum_phase(1'b0);
        acc_to_bg;
        bg_phase;
        Start = 1'b1;
        HostAck = 1'b1;
        tick;
        HostAck = 1'b0;
        chk("sa_idle_busy", Busy, 0);
        chk("sa_no_start", pe_start_sum, 0);
        tick;
        Start = 1'b0;
        chk("sa_restart", pe_start_sum, 4'hF);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
